// File: rtl/fcmp_pkg.sv
// Shared definitions for the FP compare/select pipe: op codes, operand class bits,
// and the canonical quiet NaN pattern.
package fcmp_pkg;

   localparam logic [2:0] FCMP_EQ  = 3'd0;
   localparam logic [2:0] FCMP_LT  = 3'd1;
   localparam logic [2:0] FCMP_LE  = 3'd2;
   localparam logic [2:0] FCMP_MIN = 3'd3;
   localparam logic [2:0] FCMP_MAX = 3'd4;

   // Widest operand the qNaN helper can build; callers truncate to their width.
   localparam int FCMP_QNAN_W = 128;

   typedef struct packed {
      logic is_zero;
      logic is_nan;
      logic is_snan;
   } fcmp_class_t;

   // {sign=0, exponent all ones, mantissa MSB set, rest zero}
   function automatic logic [FCMP_QNAN_W-1:0] fcmp_canon_qnan(input int exp_w, input int man_w);
      logic [FCMP_QNAN_W-1:0] q;
      q = '0;
      for (int i = 0; i < FCMP_QNAN_W; i++) begin
         if (i == man_w - 1 || (i >= man_w && i < man_w + exp_w)) q[i] = 1'b1;
      end
      return q;
   endfunction

endpackage

// File: rtl/fcmp_key.sv
// Maps an IEEE-style operand onto an unsigned ordering key plus its NaN/zero class.
// Both zeros share one key, so -0 and +0 compare equal.
module fcmp_key
   import fcmp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] x,
   output logic [EXP_W+MAN_W:0] key,
   output fcmp_class_t          cls
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic         exp_ones;
   logic         man_nz;
   logic [W-1:0] mag;

   assign exp_ones    = &x[W-2:MAN_W];
   assign man_nz      = |x[MAN_W-1:0];
   assign cls.is_zero = ~|x[W-2:0];
   assign cls.is_nan  = exp_ones & man_nz;
   assign cls.is_snan = exp_ones & man_nz & ~x[MAN_W-1];

   // Negatives are inverted so larger magnitude sorts lower; positives get the MSB set.
   assign mag = cls.is_zero ? '0 : x;
   assign key = mag[W-1] ? ~mag : (mag | {1'b1, {(W-1){1'b0}}});

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined FP compare/select unit (FEQ/FLT/FLE/FMIN/FMAX) with valid/ready on both
// sides, full back-pressure, flush, and an opaque tag carried alongside each op.
module fcmp_pipe
   import fcmp_pkg::*;
#(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int STAGES    = 2,
   parameter int TAG_W     = 6,
   parameter int NAN_AWARE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [EXP_W+MAN_W:0]  in_x1,
   input  logic [EXP_W+MAN_W:0]  in_x2,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+MAN_W:0]  out_y,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_nv
);

   localparam int           W    = 1 + EXP_W + MAN_W;
   localparam logic [W-1:0] QNAN = W'(fcmp_canon_qnan(EXP_W, MAN_W));

   typedef struct packed {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic [W-1:0]     x1;
      logic [W-1:0]     x2;
      logic [W-1:0]     k1;
      logic [W-1:0]     k2;
      fcmp_class_t      c1;
      fcmp_class_t      c2;
   } stage_t;

   stage_t       in_stage;
   stage_t       cmp;
   logic         load_out;
   logic [W-1:0] res_y;
   logic         res_nv;

   fcmp_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key1 (.x(in_x1), .key(in_stage.k1), .cls(in_stage.c1));
   fcmp_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key2 (.x(in_x2), .key(in_stage.k2), .cls(in_stage.c2));

   assign in_stage.op  = in_op;
   assign in_stage.tag = in_tag;
   assign in_stage.x1  = in_x1;
   assign in_stage.x2  = in_x2;

   generate
      if (STAGES == 2) begin : g_two
         stage_t s0;
         logic   v0;
         logic   adv0;

         assign adv0     = v0 & (~out_valid | out_ready);
         assign in_ready = ~v0 | adv0;
         assign load_out = adv0;
         assign cmp      = s0;

         always_ff @(posedge clk) begin
            if (rst || flush)             v0 <= 1'b0;
            else if (in_valid && in_ready) v0 <= 1'b1;
            else if (adv0)                v0 <= 1'b0;
         end

         // NOTE: payload registers carry no reset; the stage valid bit alone qualifies them.
         always_ff @(posedge clk) begin
            if (in_valid && in_ready) s0 <= in_stage;
         end
      end else if (STAGES == 1) begin : g_one
         assign in_ready = ~out_valid | out_ready;
         assign load_out = in_valid & in_ready;
         assign cmp      = in_stage;
      end else begin : g_bad
         $error("fcmp_pipe: STAGES must be 1 or 2");
      end
   endgenerate

   logic lt, eq, zero_tie, any_nan, any_snan, both_nan, pick_min_a, pick_max_a;

   assign lt         = cmp.k1 < cmp.k2;
   assign eq         = cmp.k1 == cmp.k2;
   // Equal zeros of opposite sign: the sign bit decides min/max.
   assign zero_tie   = eq & cmp.c1.is_zero & cmp.c2.is_zero;
   assign pick_min_a = lt | (zero_tie & cmp.x1[W-1]);
   assign pick_max_a = ~lt & ~(zero_tie & cmp.x1[W-1]);
   assign any_nan    = (NAN_AWARE != 0) & (cmp.c1.is_nan | cmp.c2.is_nan);
   assign both_nan   = (NAN_AWARE != 0) & cmp.c1.is_nan & cmp.c2.is_nan;
   assign any_snan   = (NAN_AWARE != 0) & (cmp.c1.is_snan | cmp.c2.is_snan);

   always_comb begin
      res_y  = '0;
      res_nv = 1'b0;
      case (cmp.op)
         FCMP_EQ: begin
            res_y[0] = eq & ~any_nan;
            res_nv   = any_snan;
         end
         FCMP_LT: begin
            res_y[0] = lt & ~any_nan;
            res_nv   = any_nan;
         end
         FCMP_LE: begin
            res_y[0] = (lt | eq) & ~any_nan;
            res_nv   = any_nan;
         end
         FCMP_MIN, FCMP_MAX: begin
            res_nv = any_snan;
            if (both_nan)                              res_y = QNAN;
            else if (any_nan && cmp.c1.is_nan)         res_y = cmp.x2;
            else if (any_nan)                          res_y = cmp.x1;
            else if (cmp.op == FCMP_MIN)               res_y = pick_min_a ? cmp.x1 : cmp.x2;
            else                                       res_y = pick_max_a ? cmp.x1 : cmp.x2;
         end
         default: res_nv = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_tag   <= '0;
         out_nv    <= 1'b0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (load_out)  out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
         if (load_out) begin
            out_y   <= res_y;
            out_tag <= cmp.tag;
            out_nv  <= res_nv;
         end
      end
   end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed bench for fcmp_pipe: single-precision 2-stage instance plus a
// double-precision instance for wide-operand and mid-stream reset cases.
module tb_fcmp_pipe;
   import fcmp_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_nv;
   logic [2:0]  in_op;
   logic [31:0] in_x1, in_x2, out_y;
   logic [5:0]  in_tag, out_tag;

   logic        d_rst, d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_nv;
   logic [2:0]  d_op;
   logic [63:0] d_x1, d_x2, d_y;
   logic [5:0]  d_tag, d_out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2), .TAG_W(6), .NAN_AWARE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_tag(out_tag), .out_nv(out_nv)
   );

   fcmp_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(2), .TAG_W(6), .NAN_AWARE(1)) dut_d (
      .clk(clk), .rst(d_rst), .flush(d_flush),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_op),
      .in_x1(d_x1), .in_x2(d_x2), .in_tag(d_tag),
      .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_y(d_y), .out_tag(d_out_tag), .out_nv(d_out_nv)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One isolated op on the single-precision unit with out_ready held high.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag,
                         input logic [31:0] exp_y, input logic exp_nv);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_x1 = a; in_x2 = b; in_tag = tag; out_ready = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      check({name, "_lat"}, 64'(lat), 64'd2);
      check({name, "_y"},   64'(out_y), 64'(exp_y));
      check({name, "_nv"},  64'(out_nv), 64'(exp_nv));
      check({name, "_tag"}, 64'(out_tag), 64'(tag));
   endtask

   initial begin
      int sent, rcv;
      logic stalled;
      logic [31:0] held_y;
      logic [5:0]  held_tag;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_x1 = '0; in_x2 = '0; in_tag = '0;
      d_rst = 1'b1; d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
      d_op = '0; d_x1 = '0; d_x2 = '0; d_tag = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0; d_rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_y",     64'(out_y), 64'd0);
      check("rst_out_tag",   64'(out_tag), 64'd0);
      check("rst_out_nv",    64'(out_nv), 64'd0);
      check("rst_in_ready",  64'(in_ready), 64'd1);

      run_op("fle_1_2",    FCMP_LE,  32'h3F800000, 32'h40000000, 6'd1,  32'h00000001, 1'b0);
      run_op("fle_2_1",    FCMP_LE,  32'h40000000, 32'h3F800000, 6'd2,  32'h00000000, 1'b0);
      run_op("fle_eq",     FCMP_LE,  32'h3F800000, 32'h3F800000, 6'd3,  32'h00000001, 1'b0);
      run_op("flt_eq",     FCMP_LT,  32'h3F800000, 32'h3F800000, 6'd4,  32'h00000000, 1'b0);
      run_op("feq_zeros",  FCMP_EQ,  32'h80000000, 32'h00000000, 6'd5,  32'h00000001, 1'b0);
      run_op("flt_neg",    FCMP_LT,  32'hBF800000, 32'h80000000, 6'd6,  32'h00000001, 1'b0);
      run_op("flt_inf",    FCMP_LT,  32'hFF800000, 32'h7F800000, 6'd7,  32'h00000001, 1'b0);
      run_op("fmin_zeros", FCMP_MIN, 32'h80000000, 32'h00000000, 6'd8,  32'h80000000, 1'b0);
      run_op("fmin_zr2",   FCMP_MIN, 32'h00000000, 32'h80000000, 6'd9,  32'h80000000, 1'b0);
      run_op("fmax_zeros", FCMP_MAX, 32'h80000000, 32'h00000000, 6'd10, 32'h00000000, 1'b0);
      run_op("fmax_neg",   FCMP_MAX, 32'hC0000000, 32'hBF800000, 6'd11, 32'hBF800000, 1'b0);
      run_op("fmin_mixed", FCMP_MIN, 32'h40000000, 32'hC0000000, 6'd12, 32'hC0000000, 1'b0);
      run_op("flt_qnan",   FCMP_LT,  32'h7FC00000, 32'h3F800000, 6'd13, 32'h00000000, 1'b1);
      run_op("feq_qnan",   FCMP_EQ,  32'h7FC00000, 32'h3F800000, 6'd14, 32'h00000000, 1'b0);
      run_op("feq_snan",   FCMP_EQ,  32'h7F800001, 32'h3F800000, 6'd15, 32'h00000000, 1'b1);
      run_op("fmax_snan",  FCMP_MAX, 32'h7F800001, 32'h3F800000, 6'd16, 32'h3F800000, 1'b1);
      run_op("fmin_qnan2", FCMP_MIN, 32'h3F800000, 32'h7FC00000, 6'd17, 32'h3F800000, 1'b0);
      run_op("fmin_2nan",  FCMP_MIN, 32'h7FC00000, 32'h7FC00000, 6'd18, 32'h7FC00000, 1'b0);
      run_op("fmax_2nan",  FCMP_MAX, 32'hFFC00001, 32'h7F800001, 6'd19, 32'h7FC00000, 1'b1);
      run_op("reserved",   3'd5,     32'h3F800000, 32'h40000000, 6'd20, 32'h00000000, 1'b1);

      // Back-to-back stream with the consumer stalled for cycles 3..6.
      sent = 0; rcv = 0; stalled = 1'b0; held_y = '0; held_tag = '0;
      for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 6);
         in_valid  = (sent < 8);
         in_op     = FCMP_MIN;
         in_x1     = 32'h3F800000 + 32'(sent);
         in_x2     = 32'h40000000;
         in_tag    = 6'(sent);
         #1;
         if (out_valid) begin
            if (stalled) begin
               check("b2b_hold_y",   64'(out_y), 64'(held_y));
               check("b2b_hold_tag", 64'(out_tag), 64'(held_tag));
            end
            if (out_ready) begin
               check("b2b_tag", 64'(out_tag), 64'(rcv));
               check("b2b_y",   64'(out_y), 64'(32'h3F800000 + 32'(rcv)));
               rcv++;
            end
            stalled  = !out_ready;
            held_y   = out_y;
            held_tag = out_tag;
         end else begin
            stalled = 1'b0;
         end
         if (in_valid && in_ready) sent++;
      end
      check("b2b_count", 64'(rcv), 64'd8);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("b2b_no_dup", 64'(out_valid), 64'd0);

      // Flush with two ops in flight and a third offered in the same cycle.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_op = FCMP_MAX;
      in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 6'd30;
      @(negedge clk);
      in_tag = 6'd31;
      @(negedge clk);
      check("flush_pre_valid", 64'(out_valid), 64'd1);
      check("flush_pre_tag",   64'(out_tag), 64'd30);
      flush = 1'b1; out_ready = 1'b1; in_tag = 6'd32;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_v1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("flush_v2", 64'(out_valid), 64'd0);
      run_op("post_flush", FCMP_MAX, 32'h3F800000, 32'h40000000, 6'd33, 32'h40000000, 1'b0);

      // Double precision: ordering of negatives, then reset with ops in flight.
      @(negedge clk);
      d_in_valid = 1'b1; d_op = FCMP_LT; d_tag = 6'd5; d_out_ready = 1'b1;
      d_x1 = 64'hC000000000000000; d_x2 = 64'hBFF0000000000000;
      @(negedge clk);
      d_in_valid = 1'b0;
      @(negedge clk);
      check("dp_flt_valid", 64'(d_out_valid), 64'd1);
      check("dp_flt_y",     d_y, 64'd1);
      check("dp_flt_tag",   64'(d_out_tag), 64'd5);
      d_in_valid = 1'b1; d_op = FCMP_MIN; d_tag = 6'd6;
      @(negedge clk);
      d_tag = 6'd7; d_out_ready = 1'b0;
      @(negedge clk);
      check("dp_fmin_valid", 64'(d_out_valid), 64'd1);
      check("dp_fmin_y",     d_y, 64'hC000000000000000);
      d_rst = 1'b1; d_in_valid = 1'b0;
      @(negedge clk);
      d_rst = 1'b0;
      check("dp_rst_valid", 64'(d_out_valid), 64'd0);
      check("dp_rst_y",     d_y, 64'd0);
      check("dp_rst_tag",   64'(d_out_tag), 64'd0);
      @(negedge clk);
      check("dp_rst_valid2", 64'(d_out_valid), 64'd0);
      check("dp_rst_ready",  64'(d_in_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
